bmu_req_arbiter: RTL and testbench

- Shares one BMU instance between NUM_REQ requesters, such as issue lanes or a test sequencer.
- Arbitrates round-robin, registers the granted operands and op vector into the BMU, tracks the BMU's 1-cycle registered latency, and returns each result tagged with its requester ID.
- Responses pass through a credit-protected FIFO, so downstream backpressure never drops a BMU result.

---
 rtl/bmu_req_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_bmu_req_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bmu_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : bmu_req_arbiter
//  Purpose  : Round-robin sharing of one BMU between NUM_REQ requesters.
//             Grants are issued into a registered S1 stage that drives the BMU.
//             The BMU has a 1-cycle registered latency, so its result is
//             captured in the S2 stage and pushed into a credit-protected
//             response FIFO tagged with the requester ID.
//  Options  : BMU_ARB_OPCHK_EN - reject op vectors that are not one-hot
//             (ignoring unsign/zbb). A rejected op is still granted, but it
//             travels as a bubble that returns result=0, error=1.
//  Revision : 1.0 - initial release
// ============================================================================
module bmu_req_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int OPW       = 23,
    parameter int RSP_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*32-1:0]      req_a,
    input  logic [NUM_REQ*32-1:0]      req_b,
    input  logic [NUM_REQ*OPW-1:0]     req_op,
    output logic                       bmu_valid_in,
    output logic [31:0]                bmu_a_in,
    output logic [31:0]                bmu_b_in,
    output logic [OPW-1:0]             bmu_ap,
    input  logic [31:0]                bmu_result,
    input  logic                       bmu_error,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [31:0]                rsp_result,
    output logic                       rsp_error,
    output logic                       busy
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int AW  = $clog2(RSP_DEPTH);
    localparam int CW  = $clog2(RSP_DEPTH + 1);
    localparam int EW  = IDW + 33;
    localparam logic [CW:0] c_depth = (CW+1)'(RSP_DEPTH);

    // Round-robin pointer and pipeline stages
    logic [IDW-1:0] r_ptr;
    logic           r_s1_v, r_s1_bad;
    logic [IDW-1:0] r_s1_id;
    logic [31:0]    r_s1_a, r_s1_b;
    logic [OPW-1:0] r_s1_op;
    logic           r_s2_v, r_s2_bad;
    logic [IDW-1:0] r_s2_id;

    // Response FIFO
    logic [EW-1:0]  r_mem [RSP_DEPTH];
    logic [AW-1:0]  r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]  r_count;

    // Combinational grant path
    logic           w_found, w_credit_ok, w_grant, w_op_bad;
    logic [IDW-1:0] w_gnt_idx, w_ptr_nxt;
    logic [IDW:0]   w_scan;
    logic [CW:0]    w_used;
    logic [31:0]    w_sel_a, w_sel_b;
    logic [OPW-1:0] w_sel_op;
    logic           w_push, w_pop;
    logic [EW-1:0]  w_push_data;

    // Scan from the pointer with wrap; first valid requester wins
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_scan    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scan = {1'b0, r_ptr} + (IDW+1)'(k);
            if (w_scan >= (IDW+1)'(NUM_REQ))
                w_scan = w_scan - (IDW+1)'(NUM_REQ);
            if (!w_found && req_valid[w_scan[IDW-1:0]]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_scan[IDW-1:0];
            end
        end
    end

    // Operand mux for the winning requester
    always_comb begin
        w_sel_a  = '0;
        w_sel_b  = '0;
        w_sel_op = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDW'(i) == w_gnt_idx) begin
                w_sel_a  = req_a[32*i +: 32];
                w_sel_b  = req_b[32*i +: 32];
                w_sel_op = req_op[OPW*i +: OPW];
            end
        end
    end

`ifdef BMU_ARB_OPCHK_EN
    logic [OPW-1:0] w_op_masked;
    // Legal op: exactly one function bit once unsign and zbb modifiers are ignored
    always_comb begin
        w_op_masked     = w_sel_op;
        w_op_masked[7]  = 1'b0;
        w_op_masked[20] = 1'b0;
        w_op_bad = (w_op_masked == '0) ||
                   ((w_op_masked & (w_op_masked - OPW'(1))) != '0);
    end
`else
    assign w_op_bad = 1'b0;
`endif

    // Credit: queued plus in-flight entries must leave room in the FIFO
    assign w_used      = {1'b0, r_count} + (CW+1)'(r_s1_v) + (CW+1)'(r_s2_v);
    assign w_credit_ok = (w_used < c_depth);
    assign w_grant     = w_found & w_credit_ok & ~rst;
    assign w_ptr_nxt   = (w_gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : w_gnt_idx + IDW'(1);

    // One-hot grant to the winner
    always_comb begin
        req_ready = '0;
        if (w_grant)
            req_ready[w_gnt_idx] = 1'b1;
    end

    // Pointer advances past the granted requester
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_ptr <= '0;
        else if (w_grant)
            r_ptr <= w_ptr_nxt;
    end

    // S1 issue stage; operands are zeroed when nothing (or a rejected op) issues
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_v   <= 1'b0;
            r_s1_bad <= 1'b0;
            r_s1_id  <= '0;
            r_s1_a   <= '0;
            r_s1_b   <= '0;
            r_s1_op  <= '0;
        end else begin
            r_s1_v   <= w_grant;
            r_s1_bad <= w_grant & w_op_bad;
            r_s1_id  <= w_grant ? w_gnt_idx : '0;
            r_s1_a   <= (w_grant && !w_op_bad) ? w_sel_a  : '0;
            r_s1_b   <= (w_grant && !w_op_bad) ? w_sel_b  : '0;
            r_s1_op  <= (w_grant && !w_op_bad) ? w_sel_op : '0;
        end
    end

    assign bmu_valid_in = r_s1_v & ~r_s1_bad;
    assign bmu_a_in     = r_s1_a;
    assign bmu_b_in     = r_s1_b;
    assign bmu_ap       = r_s1_op;

    // S2 return stage lines up with the BMU's registered result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_v   <= 1'b0;
            r_s2_bad <= 1'b0;
            r_s2_id  <= '0;
        end else begin
            r_s2_v   <= r_s1_v;
            r_s2_bad <= r_s1_bad;
            r_s2_id  <= r_s1_id;
        end
    end

    assign w_push      = r_s2_v;
    assign w_pop       = (r_count != '0) & rsp_ready;
    assign w_push_data = {r_s2_id,
                          r_s2_bad ? 32'd0 : bmu_result,
                          r_s2_bad | bmu_error};

    // FIFO storage needs no reset; pointers and count define occupancy
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= w_push_data;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)
                r_count <= r_count + CW'(1);
            else if (!w_push && w_pop)
                r_count <= r_count - CW'(1);
        end
    end

    assign rsp_valid  = (r_count != '0);
    assign rsp_id     = r_mem[r_rd_ptr][EW-1 -: IDW];
    assign rsp_result = r_mem[r_rd_ptr][32:1];
    assign rsp_error  = r_mem[r_rd_ptr][0];
    assign busy       = r_s1_v | r_s2_v | (r_count != '0);

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_push && !w_pop && (r_count == CW'(RSP_DEPTH))));

endmodule
`default_nettype wire

// File: tb/tb_bmu_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bmu_req_arbiter
//  Purpose  : Directed self-checking bench for bmu_req_arbiter with a small
//             behavioural BMU stand-in (1-cycle registered result).
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bmu_req_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int OPW       = 23;
    localparam int RSP_DEPTH = 4;
    localparam logic [22:0] c_op_add  = 23'h000200;
    localparam logic [22:0] c_op_sub  = 23'h000040;
    localparam logic [22:0] c_op_land = 23'h010000;
    localparam logic [22:0] c_op_cpop = 23'h000010;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [NUM_REQ-1:0]     req_valid = '0;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*32-1:0]  req_a = '0;
    logic [NUM_REQ*32-1:0]  req_b = '0;
    logic [NUM_REQ*OPW-1:0] req_op = '0;
    logic                   bmu_valid_in;
    logic [31:0]            bmu_a_in, bmu_b_in;
    logic [OPW-1:0]         bmu_ap;
    logic [31:0]            bmu_result = '0;
    logic                   bmu_error = 1'b0;
    logic                   rsp_valid;
    logic                   rsp_ready = 1'b1;
    logic [1:0]             rsp_id;
    logic [31:0]            rsp_result;
    logic                   rsp_error;
    logic                   busy;

    int errors = 0;
    int checks = 0;

    bmu_req_arbiter #(.NUM_REQ(NUM_REQ), .OPW(OPW), .RSP_DEPTH(RSP_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .bmu_valid_in(bmu_valid_in), .bmu_a_in(bmu_a_in), .bmu_b_in(bmu_b_in),
        .bmu_ap(bmu_ap), .bmu_result(bmu_result), .bmu_error(bmu_error),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_error(rsp_error), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural BMU: add/sub with signed-overflow error, land/andn, cpop
    function automatic logic [32:0] bmu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [22:0] op);
        logic [31:0] r;
        logic        e;
        r = '0;
        e = 1'b0;
        if (op[9]) begin
            r = a + b;
            e = !op[7] && (a[31] == b[31]) && (r[31] != a[31]);
        end else if (op[6]) begin
            r = a - b;
            e = !op[7] && (a[31] != b[31]) && (r[31] != a[31]);
        end else if (op[16]) begin
            r = op[20] ? (a & ~b) : (a & b);
        end else if (op[4]) begin
            r = 32'($countones(a));
        end else begin
            e = 1'b1;
        end
        return {e, r};
    endfunction

    always @(posedge clk)
        if (bmu_valid_in)
            {bmu_error, bmu_result} <= bmu_model(bmu_a_in, bmu_b_in, bmu_ap);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [22:0] op);
        req_a[32*i +: 32]   = a;
        req_b[32*i +: 32]   = b;
        req_op[OPW*i +: OPW] = op;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Leaves time at a negedge where rsp_valid=1, or reports a timeout
    task automatic wait_rsp(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid)
            check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(busy), 32'd0);
        step();
    endtask

    initial begin
        int grants;
        int nrsp;
        int saw;
        logic resumed;
        logic [1:0] exp_order [5];
        exp_order[0] = 2'd0; exp_order[1] = 2'd1; exp_order[2] = 2'd2;
        exp_order[3] = 2'd3; exp_order[4] = 2'd0;

        // Reset state, with requests already pending
        req_valid = '1;
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_bmu_valid", 32'(bmu_valid_in), 32'd0);
        check("rst_bmu_a", bmu_a_in, 32'd0);
        do_reset();

        // Single add, latency check
        set_req(0, 32'd5, 32'd7, c_op_add);
        req_valid = 4'b0001;
        @(negedge clk);
        check("add_grant", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        @(negedge clk);
        check("add_issue_v", 32'(bmu_valid_in), 32'd1);
        check("add_issue_a", bmu_a_in, 32'd5);
        check("add_issue_ap", 32'(bmu_ap), 32'h200);
        step();
        @(negedge clk);
        check("add_early", 32'(rsp_valid), 32'd0);
        step();
        @(negedge clk);
        check("add_rsp_v", 32'(rsp_valid), 32'd1);
        check("add_rsp_id", 32'(rsp_id), 32'd0);
        check("add_rsp_res", rsp_result, 32'd12);
        check("add_rsp_err", 32'(rsp_error), 32'd0);
        step();
        @(negedge clk);
        check("add_idle", 32'(busy), 32'd0);

        // Round-robin fairness with all four requesting
        do_reset();
        for (int i = 0; i < NUM_REQ; i++)
            set_req(i, 32'hFFFF0000 | 32'(i * 32'h11), 32'h0000FFFF, c_op_land);
        req_valid = 4'b1111;
        nrsp = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c < 5)
                check($sformatf("rr_grant%0d", c), 32'(req_ready), 32'(1) << exp_order[c]);
            if (rsp_valid && nrsp < 5) begin
                check($sformatf("rr_id%0d", nrsp), 32'(rsp_id), 32'(exp_order[nrsp]));
                check($sformatf("rr_res%0d", nrsp), rsp_result, 32'(exp_order[nrsp]) * 32'h11);
                nrsp++;
            end
            step();
            if (c == 4)
                req_valid = '0;
        end
        check("rr_count", 32'(nrsp), 32'd5);

        // Overflow is passed through from the BMU
        set_req(2, 32'h7FFFFFFF, 32'd1, c_op_add);
        req_valid = 4'b0100;
        @(negedge clk);
        check("ovf_grant", 32'(req_ready), 32'h4);
        step();
        req_valid = '0;
        wait_rsp("ovf");
        check("ovf_id", 32'(rsp_id), 32'd2);
        check("ovf_res", rsp_result, 32'h80000000);
        check("ovf_err", 32'(rsp_error), 32'd1);
        step();

        // Backpressure: credit allows exactly RSP_DEPTH grants
        rsp_ready = 1'b0;
        set_req(1, 32'hF0F0F0F0, 32'd0, c_op_cpop);
        req_valid = 4'b0010;
        grants = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            grants += int'(req_ready[1]);
            step();
        end
        check("bp_grants", 32'(grants), 32'd4);
        @(negedge clk);
        check("bp_stalled", 32'(req_ready), 32'd0);
        check("bp_head_res", rsp_result, 32'd16);
        rsp_ready = 1'b1;
        nrsp = 0;
        resumed = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            @(negedge clk);
            if (rsp_valid && nrsp < 4) begin
                check($sformatf("bp_res%0d", nrsp), rsp_result, 32'd16);
                check($sformatf("bp_id%0d", nrsp), 32'(rsp_id), 32'd1);
                nrsp++;
            end
            if (req_ready[1])
                resumed = 1'b1;
        end
        check("bp_drained", 32'(nrsp), 32'd4);
        check("bp_resumed", 32'(resumed), 32'd1);
        step();
        req_valid = '0;
        wait_idle("bp_idle");

        // Reset one cycle after granting a sub discards it
        set_req(3, 32'd10, 32'd3, c_op_sub);
        req_valid = 4'b1000;
        @(negedge clk);
        check("mid_grant", 32'(req_ready), 32'h8);
        step();
        req_valid = '0;
        rst = 1'b1;
        @(negedge clk);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_bmu_v", 32'(bmu_valid_in), 32'd0);
        step();
        rst = 1'b0;
        saw = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            saw += int'(rsp_valid);
            step();
        end
        check("mid_no_rsp", 32'(saw), 32'd0);
        check("mid_busy_after", 32'(busy), 32'd0);
        req_valid = 4'b1111;
        @(negedge clk);
        check("mid_ptr0", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        wait_idle("mid_idle");

`ifdef BMU_ARB_OPCHK_EN
        // Illegal op becomes a bubble returning error
        set_req(0, 32'd1, 32'd2, 23'h000240);
        req_valid = 4'b0001;
        @(negedge clk);
        check("chk_bad_grant", 32'(req_ready[0]), 32'd1);
        step();
        req_valid = '0;
        @(negedge clk);
        check("chk_bad_novalid", 32'(bmu_valid_in), 32'd0);
        wait_rsp("chk_bad");
        check("chk_bad_res", rsp_result, 32'd0);
        check("chk_bad_err", 32'(rsp_error), 32'd1);
        step();
        // zbb modifier is ignored by the legality check
        set_req(0, 32'h000000FF, 32'h0000000F, 23'h110000);
        req_valid = 4'b0001;
        @(negedge clk);
        check("chk_ok_grant", 32'(req_ready[0]), 32'd1);
        step();
        req_valid = '0;
        wait_rsp("chk_ok");
        check("chk_ok_res", rsp_result, 32'h000000F0);
        check("chk_ok_err", 32'(rsp_error), 32'd0);
        step();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
